axi_read_arbiter_n: RTL and testbench
=====================================

Name: axi_read_arbiter_n

Overview:
N-channel AXI4 read-port arbiter. It merges per-channel line-fill and uncached single-word read requests onto one AXI read master, and routes returned beats back to the granted channel. It generalises the fixed icache/dcache/uncached read path to a parametrised channel count, with selectable fixed or round-robin priority, per-channel cacheability, response-error reporting and protocol checking. It sits between the cache/uncached request sources and the SoC AXI read bus. At most one burst is outstanding at a time.

Parameters:
N_CH, 4, number of request channels (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
ID_W, 4, AXI ID width; arid = ID_BASE + granted channel index
ID_BASE, 0, first AXI ID used
PRIO_MODE, 1, 0 = fixed (lowest index wins), 1 = round-robin
MAX_LEN, 16, maximum burst beats; requests with len+1 > MAX_LEN are clamped to MAX_LEN-1

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req_valid  in  N_CH  per-channel request valid
o_req_ready  out  N_CH  one-hot accept pulse
i_req_addr  in  N_CH*ADDR_W  start address, channel k in slice k
i_req_len  in  N_CH*8  beats-1
i_req_size  in  N_CH*3  AXI size
i_req_cached  in  N_CH  1 = cacheable (arcache 4'b1111), 0 = uncached (4'b0000)
o_resp_valid  out  N_CH  one-hot beat valid to the granted channel
o_resp_data  out  DATA_W  beat data, shared by all channels
o_resp_last  out  1  final beat
o_resp_err  out  1  rresp != 0 on the current beat
o_busy  out  1  state != IDLE
o_proto_err  out  1  sticky protocol error flag
arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  ID_W/ADDR_W/8/3/2/2/4/3/1  AXI AR channel
arready  in  1  AXI AR ready
rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  AXI R channel
rready  out  1  AXI R ready

Behaviour:
- Clock/reset: single clock i_clk; i_rst is synchronous, active-high.
- Reset values:
  - state = IDLE; arvalid = 0; rready = 0.
  - o_req_ready, o_resp_valid, o_resp_last, o_resp_err = 0; o_busy = 0; o_proto_err = 0.
  - RR pointer = 0; beat counter = 0; all AR registers = 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any i_req_valid is set, select grant g. PRIO_MODE 0 picks the lowest set index. PRIO_MODE 1 picks the first set index at or after the RR pointer, with modulo N_CH wrap.
  - Same cycle: o_req_ready[g] = 1 (combinational). Latch addr, clamped len, size and cached for g, plus g itself.
  - Next cycle: ADDR with arvalid = 1.
- ADDR:
  - AR outputs come from registers and stay stable while arvalid is high.
  - arburst = 2'b01 (INCR); arlock = 0; arprot = 0.
  - On arvalid && arready go to DATA. arvalid drops the next cycle. Beat counter = 0.
- DATA:
  - rready = 1.
  - Each beat (rvalid && rready): o_resp_valid[g] = 1, o_resp_data = rdata, o_resp_last = rlast, o_resp_err = |rresp. All of these are combinational, zero latency. Beat counter increments.
  - On the rlast beat: go to IDLE and set RR pointer = (g+1) mod N_CH. A new grant is possible in the very next cycle.
- Request-side rules:
  - Channels must hold i_req_valid and their fields stable until o_req_ready.
  - Non-granted channels see no effect.
  - A channel that deasserts valid before grant is simply dropped.
- Protocol checks (each sets o_proto_err sticky until reset; the transfer still continues):
  - rid != arid during DATA.
  - rlast on a beat where counter != latched len.
  - Counter reaching latched len without rlast. Extra beats are still forwarded; the burst ends only on rlast.
  - rvalid in IDLE/ADDR is not accepted (rready = 0).
- Arithmetic: beat counter is 8-bit. Len is compared after clamping. The ID sum ID_BASE+g is truncated to ID_W.
- Reset mid-operation:
  - Returns to IDLE immediately and clears arvalid/rready.
  - Leftover R beats of the aborted burst are not accepted until a new burst reaches DATA. They then raise o_proto_err through the rid/length checks.

Test Plan:
1. Single request, ch2, addr 0x1FC0_0000, len 0, cached 0 -> arid = 2, arlen = 0, arcache = 0; one o_resp_valid[2] beat with rlast; o_busy falls the next cycle.
2. PRIO_MODE 1, channels 0, 1, 3 all valid continuously with len 15 each -> grant order 0, 1, 3, 0; each burst delivers 16 beats, only the last having o_resp_last.
3. PRIO_MODE 0, channels 1 and 3 valid -> ch1 is granted repeatedly and ch3 is starved while ch1 stays valid.
4. arready held low for 5 cycles -> arvalid stays high with AR fields constant; DATA is entered only after the handshake.
5. rresp = 2'b10 on beat 3 of 16 -> o_resp_err high for that beat only; o_proto_err stays 0.
6. Early rlast on beat 4 of a len 7 burst -> o_proto_err goes to 1 and FSM returns to IDLE. Reset mid-ADDR -> next cycle arvalid = 0, o_proto_err = 0, o_busy = 0.

Source files
------------

// File: rtl/axi_read_arbiter_n.sv
// axi_read_arbiter_n
// ------------------
// N-channel AXI4 read-port arbiter. Line-fill and uncached single-word read
// requests from N_CH sources are merged onto one AXI read master. Only one
// burst is outstanding at a time. Returned R beats are steered back to the
// channel that owns the burst.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid/o_req_ready per-channel request handshake (ready is a one-hot
//                           pulse in the cycle the request is accepted)
//   i_req_addr/len/size     per-channel request fields, channel k in slice k
//   i_req_cached            1 = cacheable (arcache 4'b1111), 0 = uncached
//   o_resp_valid            one-hot beat strobe to the granted channel
//   o_resp_data/last/err    shared beat payload, last flag, rresp != 0
//   o_busy                  arbiter is not idle
//   o_proto_err             sticky AXI response protocol violation flag
//   ar*/arready             AXI read address channel (master side)
//   rid/rdata/rresp/rlast/rvalid/rready   AXI read data channel

module axi_read_arbiter_n #(
    parameter int N_CH      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int ID_BASE   = 0,
    parameter int PRIO_MODE = 1,
    parameter int MAX_LEN   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,

    input  logic [N_CH-1:0]        i_req_valid,
    output logic [N_CH-1:0]        o_req_ready,
    input  logic [N_CH*ADDR_W-1:0] i_req_addr,
    input  logic [N_CH*8-1:0]      i_req_len,
    input  logic [N_CH*3-1:0]      i_req_size,
    input  logic [N_CH-1:0]        i_req_cached,

    output logic [N_CH-1:0]      o_resp_valid,
    output logic [DATA_W-1:0]    o_resp_data,
    output logic                 o_resp_last,
    output logic                 o_resp_err,
    output logic                 o_busy,
    output logic                 o_proto_err,

    output logic [ID_W-1:0]      arid,
    output logic [ADDR_W-1:0]    araddr,
    output logic [7:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic [1:0]           arlock,
    output logic [3:0]           arcache,
    output logic [2:0]           arprot,
    output logic                 arvalid,
    input  logic                 arready,

    input  logic [ID_W-1:0]      rid,
    input  logic [DATA_W-1:0]    rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [IDX_W-1:0]   gnt_reg;
    logic [IDX_W-1:0]   gnt_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [7:0]         beat_cnt;
    logic               proto_err;

    logic               any_req;
    logic               found;
    int                 scan_idx;
    logic [7:0]         sel_len_raw;
    logic [7:0]         sel_len;
    logic               beat;

    // Grant selection. Fixed mode scans from index 0; round-robin mode scans
    // from the pointer and wraps, so the channel after the last owner gets
    // the first chance.
    always_comb begin
        any_req  = |i_req_valid;
        found    = 1'b0;
        gnt_next = '0;
        scan_idx = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (PRIO_MODE == 0) begin
                scan_idx = i;
            end else begin
                scan_idx = (int'(rr_ptr) + i) % N_CH;
            end
            if (!found && i_req_valid[IDX_W'(scan_idx)]) begin
                found    = 1'b1;
                gnt_next = IDX_W'(scan_idx);
            end
        end
    end

    // Burst length clamp: anything longer than MAX_LEN beats is cut down to
    // exactly MAX_LEN beats. The compare is done in 9 bits so len 255 does
    // not wrap.
    always_comb begin
        sel_len_raw = i_req_len[int'(gnt_next)*8 +: 8];
        sel_len     = sel_len_raw;
        if (({1'b0, sel_len_raw} + 9'd1) > 9'(MAX_LEN)) begin
            sel_len = 8'(MAX_LEN - 1);
        end
    end

    // Next-state logic and the combinational request/response outputs.
    // Accept and beat strobes are zero-latency so a source sees its grant
    // and its data in the same cycle as the triggering condition.
    always_comb begin
        state_next   = state;
        o_req_ready  = '0;
        o_resp_valid = '0;
        o_resp_data  = '0;
        o_resp_last  = 1'b0;
        o_resp_err   = 1'b0;
        beat         = 1'b0;

        case (state)
            IDLE: begin
                if (any_req && !i_rst) begin
                    o_req_ready[gnt_next] = 1'b1;
                    state_next            = ADDR;
                end
            end
            ADDR: begin
                if (arready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                beat = rvalid;
                if (rvalid) begin
                    o_resp_valid[gnt_reg] = 1'b1;
                    o_resp_data           = rdata;
                    o_resp_last           = rlast;
                    o_resp_err            = |rresp;
                    if (rlast) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, latched AR fields, beat counter, round-robin pointer
    // and the sticky protocol checker. The checks only flag; the burst is
    // always terminated by rlast alone so a misbehaving slave cannot wedge
    // the arbiter in DATA.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            gnt_reg   <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            proto_err <= 1'b0;
            arid      <= '0;
            araddr    <= '0;
            arlen     <= '0;
            arsize    <= '0;
            arcache   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_reg <= gnt_next;
                        arid    <= ID_W'(ID_BASE + int'(gnt_next));
                        araddr  <= i_req_addr[int'(gnt_next)*ADDR_W +: ADDR_W];
                        arlen   <= sel_len;
                        arsize  <= i_req_size[int'(gnt_next)*3 +: 3];
                        arcache <= i_req_cached[gnt_next] ? 4'b1111 : 4'b0000;
                    end
                end
                ADDR: begin
                    if (arready) begin
                        beat_cnt <= '0;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if ((rid != arid) ||
                            (rlast && (beat_cnt != arlen)) ||
                            (!rlast && (beat_cnt == arlen))) begin
                            proto_err <= 1'b1;
                        end
                        if (rlast) begin
                            rr_ptr <= (gnt_reg == IDX_W'(N_CH - 1)) ? '0 : gnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign arvalid     = (state == ADDR);
    assign rready      = (state == DATA);
    assign arburst     = 2'b01;
    assign arlock      = 2'b00;
    assign arprot      = 3'b000;
    assign o_busy      = (state != IDLE);
    assign o_proto_err = proto_err;

endmodule

// File: tb/tb_axi_read_arbiter_n.sv
// tb_axi_read_arbiter_n
// ---------------------
// Directed bench for axi_read_arbiter_n. Two instances share every input:
// one round-robin, one fixed-priority. They advance in lockstep because the
// handshake timing is driven identically; the active checks follow the
// instance selected by use_fx.

module tb_axi_read_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0]  req_len;
    logic [N*3-1:0]  req_size;
    logic [N-1:0]    req_cached;
    logic            arready;
    logic [IW-1:0]   rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;

    logic [N-1:0]  rr_req_ready, fx_req_ready, s_req_ready;
    logic [N-1:0]  rr_resp_valid, fx_resp_valid, s_resp_valid;
    logic [DW-1:0] rr_resp_data, fx_resp_data, s_resp_data;
    logic          rr_resp_last, fx_resp_last, s_resp_last;
    logic          rr_resp_err, fx_resp_err, s_resp_err;
    logic          rr_busy, fx_busy, s_busy;
    logic          rr_proto_err, fx_proto_err, s_proto_err;
    logic [IW-1:0] rr_arid, fx_arid, s_arid;
    logic [AW-1:0] rr_araddr, fx_araddr, s_araddr;
    logic [7:0]    rr_arlen, fx_arlen, s_arlen;
    logic [2:0]    rr_arsize, fx_arsize, s_arsize;
    logic [1:0]    rr_arburst, fx_arburst, s_arburst;
    logic [1:0]    rr_arlock, fx_arlock, s_arlock;
    logic [3:0]    rr_arcache, fx_arcache, s_arcache;
    logic [2:0]    rr_arprot, fx_arprot, s_arprot;
    logic          rr_arvalid, fx_arvalid, s_arvalid;
    logic          rr_rready, fx_rready, s_rready;

    logic use_fx;
    int   checks;
    int   failures;

    axi_read_arbiter_n #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
                         .ID_BASE(0), .PRIO_MODE(1), .MAX_LEN(16)) dut_rr (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(rr_req_ready),
        .i_req_addr(req_addr), .i_req_len(req_len), .i_req_size(req_size),
        .i_req_cached(req_cached),
        .o_resp_valid(rr_resp_valid), .o_resp_data(rr_resp_data),
        .o_resp_last(rr_resp_last), .o_resp_err(rr_resp_err),
        .o_busy(rr_busy), .o_proto_err(rr_proto_err),
        .arid(rr_arid), .araddr(rr_araddr), .arlen(rr_arlen), .arsize(rr_arsize),
        .arburst(rr_arburst), .arlock(rr_arlock), .arcache(rr_arcache),
        .arprot(rr_arprot), .arvalid(rr_arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rr_rready)
    );

    axi_read_arbiter_n #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
                         .ID_BASE(0), .PRIO_MODE(0), .MAX_LEN(16)) dut_fx (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(fx_req_ready),
        .i_req_addr(req_addr), .i_req_len(req_len), .i_req_size(req_size),
        .i_req_cached(req_cached),
        .o_resp_valid(fx_resp_valid), .o_resp_data(fx_resp_data),
        .o_resp_last(fx_resp_last), .o_resp_err(fx_resp_err),
        .o_busy(fx_busy), .o_proto_err(fx_proto_err),
        .arid(fx_arid), .araddr(fx_araddr), .arlen(fx_arlen), .arsize(fx_arsize),
        .arburst(fx_arburst), .arlock(fx_arlock), .arcache(fx_arcache),
        .arprot(fx_arprot), .arvalid(fx_arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(fx_rready)
    );

    assign s_req_ready  = use_fx ? fx_req_ready  : rr_req_ready;
    assign s_resp_valid = use_fx ? fx_resp_valid : rr_resp_valid;
    assign s_resp_data  = use_fx ? fx_resp_data  : rr_resp_data;
    assign s_resp_last  = use_fx ? fx_resp_last  : rr_resp_last;
    assign s_resp_err   = use_fx ? fx_resp_err   : rr_resp_err;
    assign s_busy       = use_fx ? fx_busy       : rr_busy;
    assign s_proto_err  = use_fx ? fx_proto_err  : rr_proto_err;
    assign s_arid       = use_fx ? fx_arid       : rr_arid;
    assign s_araddr     = use_fx ? fx_araddr     : rr_araddr;
    assign s_arlen      = use_fx ? fx_arlen      : rr_arlen;
    assign s_arsize     = use_fx ? fx_arsize     : rr_arsize;
    assign s_arburst    = use_fx ? fx_arburst    : rr_arburst;
    assign s_arlock     = use_fx ? fx_arlock     : rr_arlock;
    assign s_arcache    = use_fx ? fx_arcache    : rr_arcache;
    assign s_arprot     = use_fx ? fx_arprot     : rr_arprot;
    assign s_arvalid    = use_fx ? fx_arvalid    : rr_arvalid;
    assign s_rready     = use_fx ? fx_rready     : rr_rready;

    typedef struct {
        logic [N-1:0] mask;
        logic [31:0]  addr;
        logic [7:0]   len;
        logic         cached;
        int           exp_gnt;
        logic [7:0]   exp_arlen;
        logic [3:0]   exp_arcache;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] mask, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic cached);
        req_valid = mask;
        for (int k = 0; k < N; k++) begin
            req_addr[k*AW +: AW] = addr;
            req_len[k*8 +: 8]    = len;
            req_size[k*3 +: 3]   = size;
            req_cached[k]        = cached;
        end
    endtask

    task automatic doReset();
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        req_size  = '0;
        req_cached = '0;
        arready   = 1'b0;
        rid       = '0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        rvalid    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Runs one complete burst starting in an IDLE cycle (called at posedge+1
    // with the request already driven). All checks are at the negedge.
    task automatic runBurst(input int g, input logic [31:0] addr, input logic [7:0] elen,
                            input logic [2:0] size, input logic [3:0] ecache,
                            input int ar_wait, input int err_beat, input bit drop);
        #4;
        checkOutput("idle_busy", 64'(s_busy), 64'(0));
        checkOutput("grant", 64'(s_req_ready), 64'(1) << g);
        @(posedge clk); #1;
        if (drop) req_valid = '0;
        arready = 1'b0;
        for (int w = 0; w < ar_wait; w++) begin
            #4;
            checkOutput("wait_arvalid", 64'(s_arvalid), 64'(1));
            checkOutput("wait_araddr", 64'(s_araddr), 64'(addr));
            checkOutput("wait_arlen", 64'(s_arlen), 64'(elen));
            checkOutput("wait_rready", 64'(s_rready), 64'(0));
            @(posedge clk); #1;
        end
        arready = 1'b1;
        #4;
        checkOutput("arvalid", 64'(s_arvalid), 64'(1));
        checkOutput("arid", 64'(s_arid), 64'(g));
        checkOutput("araddr", 64'(s_araddr), 64'(addr));
        checkOutput("arlen", 64'(s_arlen), 64'(elen));
        checkOutput("arsize", 64'(s_arsize), 64'(size));
        checkOutput("arburst", 64'(s_arburst), 64'(1));
        checkOutput("arcache", 64'(s_arcache), 64'(ecache));
        checkOutput("arlock_prot", 64'({s_arlock, s_arprot}), 64'(0));
        checkOutput("addr_busy", 64'(s_busy), 64'(1));
        @(posedge clk); #1;
        arready = 1'b0;
        for (int b = 0; b <= int'(elen); b++) begin
            rvalid = 1'b1;
            rid    = IW'(g);
            rdata  = DW'(32'hA500_0000 | (g << 16) | b);
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            rlast  = (b == int'(elen));
            #4;
            checkOutput("arvalid_drop", 64'(s_arvalid), 64'(0));
            checkOutput("rready", 64'(s_rready), 64'(1));
            checkOutput("resp_valid", 64'(s_resp_valid), 64'(1) << g);
            checkOutput("resp_data", 64'(s_resp_data), 64'(32'hA500_0000 | (g << 16) | b));
            checkOutput("resp_last", 64'(s_resp_last), 64'(b == int'(elen)));
            checkOutput("resp_err", 64'(s_resp_err), 64'(b == err_beat));
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        use_fx   = 1'b0;

        // Round-robin table; pointer starts at 0 after reset and moves to
        // owner+1 after each burst.
        vecs[0] = '{4'b0100, 32'h1FC0_0000, 8'd0,   1'b0, 2, 8'd0,  4'h0};
        vecs[1] = '{4'b1011, 32'h0000_1000, 8'd3,   1'b1, 3, 8'd3,  4'hF};
        vecs[2] = '{4'b0011, 32'h0000_2000, 8'd20,  1'b1, 0, 8'd15, 4'hF};
        vecs[3] = '{4'b0001, 32'h0000_3000, 8'd1,   1'b0, 0, 8'd1,  4'h0};
        vecs[4] = '{4'b1000, 32'h0000_4000, 8'd255, 1'b1, 3, 8'd15, 4'hF};

        doReset();
        #4;
        checkOutput("rst_arvalid", 64'(rr_arvalid), 64'(0));
        checkOutput("rst_rready", 64'(rr_rready), 64'(0));
        checkOutput("rst_busy", 64'(rr_busy), 64'(0));
        checkOutput("rst_proto_err", 64'(rr_proto_err), 64'(0));
        checkOutput("rst_req_ready", 64'(rr_req_ready), 64'(0));
        checkOutput("rst_resp_valid", 64'(rr_resp_valid), 64'(0));
        checkOutput("rst_araddr", 64'(rr_araddr), 64'(0));
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].mask, vecs[v].addr, vecs[v].len, 3'd2, vecs[v].cached);
            runBurst(vecs[v].exp_gnt, vecs[v].addr, vecs[v].exp_arlen, 3'd2,
                     vecs[v].exp_arcache, 0, -1, 1'b1);
        end
        #4;
        checkOutput("table_busy_after", 64'(rr_busy), 64'(0));
        checkOutput("table_proto_err", 64'(rr_proto_err), 64'(0));
        @(posedge clk); #1;

        // Round-robin with channels 0, 1, 3 held valid throughout.
        doReset();
        applyStimulus(4'b1011, 32'h2000_0000, 8'd15, 3'd2, 1'b1);
        runBurst(0, 32'h2000_0000, 8'd15, 3'd2, 4'hF, 0, -1, 1'b0);
        runBurst(1, 32'h2000_0000, 8'd15, 3'd2, 4'hF, 0, -1, 1'b0);
        runBurst(3, 32'h2000_0000, 8'd15, 3'd2, 4'hF, 0, -1, 1'b0);
        runBurst(0, 32'h2000_0000, 8'd15, 3'd2, 4'hF, 0, -1, 1'b0);
        req_valid = '0;
        #4;
        checkOutput("rr_proto_err", 64'(rr_proto_err), 64'(0));
        @(posedge clk); #1;

        // Fixed priority: channel 1 starves channel 3.
        doReset();
        use_fx = 1'b1;
        applyStimulus(4'b1010, 32'h3000_0000, 8'd1, 3'd2, 1'b0);
        runBurst(1, 32'h3000_0000, 8'd1, 3'd2, 4'h0, 0, -1, 1'b0);
        runBurst(1, 32'h3000_0000, 8'd1, 3'd2, 4'h0, 0, -1, 1'b0);
        runBurst(1, 32'h3000_0000, 8'd1, 3'd2, 4'h0, 0, -1, 1'b0);
        req_valid = '0;
        #4;
        checkOutput("fx_proto_err", 64'(fx_proto_err), 64'(0));
        @(posedge clk); #1;
        use_fx = 1'b0;

        // arready stalled for 5 cycles, then rresp error on beat 3 of 16.
        doReset();
        applyStimulus(4'b0010, 32'h8000_1000, 8'd2, 3'd2, 1'b1);
        runBurst(1, 32'h8000_1000, 8'd2, 3'd2, 4'hF, 5, -1, 1'b1);
        applyStimulus(4'b0001, 32'h4000_0040, 8'd15, 3'd2, 1'b1);
        runBurst(0, 32'h4000_0040, 8'd15, 3'd2, 4'hF, 0, 3, 1'b1);
        #4;
        checkOutput("err_proto_err", 64'(rr_proto_err), 64'(0));
        checkOutput("err_busy", 64'(rr_busy), 64'(0));
        @(posedge clk); #1;

        // Early rlast on beat 4 of a len-7 burst.
        doReset();
        applyStimulus(4'b0100, 32'h5000_0000, 8'd7, 3'd2, 1'b0);
        #4;
        checkOutput("early_grant", 64'(rr_req_ready), 64'(4'b0100));
        @(posedge clk); #1;
        req_valid = '0;
        arready   = 1'b1;
        #4;
        checkOutput("early_arlen", 64'(rr_arlen), 64'(7));
        @(posedge clk); #1;
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1;
            rid    = IW'(2);
            rdata  = DW'(32'h0BAD_0000 | b);
            rlast  = (b == 3);
            #4;
            checkOutput("early_resp_valid", 64'(rr_resp_valid), 64'(4'b0100));
            checkOutput("early_resp_last", 64'(rr_resp_last), 64'(b == 3));
            checkOutput("early_proto_before", 64'(rr_proto_err), 64'(0));
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        #4;
        checkOutput("early_proto_err", 64'(rr_proto_err), 64'(1));
        checkOutput("early_busy", 64'(rr_busy), 64'(0));
        @(posedge clk); #1;

        // Reset while in ADDR.
        applyStimulus(4'b0001, 32'h6000_0000, 8'd0, 3'd2, 1'b1);
        @(posedge clk); #1;
        req_valid = '0;
        #4;
        checkOutput("midrst_arvalid_before", 64'(rr_arvalid), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #4;
        checkOutput("midrst_arvalid", 64'(rr_arvalid), 64'(0));
        checkOutput("midrst_proto_err", 64'(rr_proto_err), 64'(0));
        checkOutput("midrst_busy", 64'(rr_busy), 64'(0));
        checkOutput("midrst_rready", 64'(rr_rready), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
